// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types for the pipeline hazard sequencer
package pipe_pkg;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10} fwd_sel_t;
  typedef enum logic [1:0] {RUN, MISS, RESUME} hz_state_t;
endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// fwd_sel: E-stage operand forwarding select, M has priority over W, x0 never forwarded
import pipe_pkg::*;
module fwd_sel #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] RsE,
  input  logic [WIDTH-1:0] RdM,
  input  logic [WIDTH-1:0] RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  output fwd_sel_t         fwd
);
  always_comb
    fwd = (RegWriteM && RdM != '0 && RdM == RsE) ? FWD_MEM :
          (RegWriteW && RdW != '0 && RdW == RsE) ? FWD_WB : FWD_RF;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush sequencing, load-use/branch hazards and data-miss freeze FSM
import pipe_pkg::*;
module hazard_ctrl #(
  parameter int WIDTH        = 5,
  parameter int MISS_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] Rs1D,
  input  logic [WIDTH-1:0] Rs2D,
  input  logic [WIDTH-1:0] Rs1E,
  input  logic [WIDTH-1:0] Rs2E,
  input  logic [WIDTH-1:0] RdE,
  input  logic [WIDTH-1:0] RdM,
  input  logic [WIDTH-1:0] RdW,
  input  logic             MemReadE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  input  logic             MissM,
  input  logic             RefillDone,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output fwd_sel_t         ForwardAE,
  output fwd_sel_t         ForwardBE,
  output logic             MemErr
);
  localparam int CW = $clog2(MISS_TIMEOUT + 1);
  hz_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic mem_err_q, mem_err_d;
  logic lw_stall;
  fwd_sel_t fwd_a, fwd_b;
  fwd_sel #(.WIDTH(WIDTH)) u_fwd_a (
    .RsE(Rs1E), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .fwd(fwd_a)
  );
  fwd_sel #(.WIDTH(WIDTH)) u_fwd_b (
    .RsE(Rs2E), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .fwd(fwd_b)
  );
  always_comb lw_stall = MemReadE && RdE != '0 && (RdE == Rs1D || RdE == Rs2D);
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_err_d = mem_err_q;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    case (state_q)
      RUN:
        if (MissM) begin
          {StallF, StallD, StallE, StallM, FlushW} = '1;
          state_d = MISS;
          cnt_d   = '0;
        end else if (PCSrcE) begin
          {FlushD, FlushE} = '1;
        end else if (lw_stall) begin
          {StallF, StallD, FlushE} = '1;
        end
      MISS: begin
        {StallF, StallD, StallE, StallM, FlushW} = '1;
        if (RefillDone) state_d = RESUME;
        else if (cnt_q == CW'(MISS_TIMEOUT - 1)) mem_err_d = 1'b1;
        else cnt_d = cnt_q + 1'b1;
      end
      RESUME: begin
        {StallF, StallD, StallE, StallM, FlushW} = '1;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    // reset clears the pipe regardless of the state being left
    if (rst) {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW} = 7'b0000111;
    ForwardAE = rst ? FWD_RF : fwd_a;
    ForwardBE = rst ? FWD_RF : fwd_b;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  always_comb MemErr = mem_err_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of forwarding, hazards, miss freeze and timeout
import pipe_pkg::*;
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic MemReadE, RegWriteM, RegWriteW, PCSrcE, MissM, RefillDone;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
  logic StallF4, StallD4, StallE4, StallM4, FlushD4, FlushE4, FlushW4, MemErr4;
  fwd_sel_t ForwardAE, ForwardBE, ForwardAE4, ForwardBE4;
  logic [6:0] ctl, ctl4;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  always_comb ctl  = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
  always_comb ctl4 = {StallF4, StallD4, StallE4, StallM4, FlushD4, FlushE4, FlushW4};
  hazard_ctrl dut (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RdM(RdM), .RdW(RdW), .MemReadE(MemReadE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .PCSrcE(PCSrcE), .MissM(MissM), .RefillDone(RefillDone), .StallF(StallF), .StallD(StallD),
    .StallE(StallE), .StallM(StallM), .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MemErr(MemErr)
  );
  hazard_ctrl #(.MISS_TIMEOUT(4)) dut4 (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RdM(RdM), .RdW(RdW), .MemReadE(MemReadE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .PCSrcE(PCSrcE), .MissM(MissM), .RefillDone(RefillDone), .StallF(StallF4), .StallD(StallD4),
    .StallE(StallE4), .StallM(StallM4), .FlushD(FlushD4), .FlushE(FlushE4), .FlushW(FlushW4),
    .ForwardAE(ForwardAE4), .ForwardBE(ForwardBE4), .MemErr(MemErr4)
  );
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    // ctl bit order: StallF StallD StallE StallM FlushD FlushE FlushW
    rst = 1'b1;
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {MemReadE, RegWriteM, RegWriteW, PCSrcE, MissM, RefillDone} = '0;
    RegWriteM = 1'b1; RdM = 5; RegWriteW = 1'b1; RdW = 5; Rs1E = 5; Rs2E = 5;
    tick;
    #1;
    chk("rst_ctl", ctl, 7'b0000111);
    chk("rst_fwdA", ForwardAE, FWD_RF);
    chk("rst_fwdB", ForwardBE, FWD_RF);
    chk("rst_memerr", MemErr, 0);
    rst = 1'b0;
    #1;
    chk("fwd_mem_A", ForwardAE, FWD_MEM);
    chk("fwd_mem_B", ForwardBE, FWD_MEM);
    chk("run_idle", ctl, 7'b0000000);
    RegWriteM = 1'b0;
    #1;
    chk("fwd_wb_A", ForwardAE, FWD_WB);
    RegWriteM = 1'b1; Rs2E = 3; RdW = 3;
    #1;
    chk("fwd_mem_over_A", ForwardAE, FWD_MEM);
    chk("fwd_wb_B", ForwardBE, FWD_WB);
    Rs1E = 0; RdM = 0; RdW = 0; Rs2E = 0;
    #1;
    chk("fwd_x0_A", ForwardAE, FWD_RF);
    chk("fwd_x0_B", ForwardBE, FWD_RF);
    RegWriteM = 1'b0; RegWriteW = 1'b0;
    tick;
    MemReadE = 1'b1; RdE = 7; Rs2D = 7;
    #1;
    chk("loaduse", ctl, 7'b1100010);
    tick;
    MemReadE = 1'b0;
    #1;
    chk("loaduse_done", ctl, 7'b0000000);
    MemReadE = 1'b1; RdE = 0; Rs1D = 0;
    #1;
    chk("loaduse_x0", ctl, 7'b0000000);
    RdE = 7;
    PCSrcE = 1'b1;
    #1;
    chk("branch_over_lw", ctl, 7'b0000110);
    tick;
    {MemReadE, PCSrcE} = '0; RdE = 0; Rs2D = 0;
    for (int i = 0; i < 5; i++) begin
      MissM = 1'b1;
      #1;
      chk($sformatf("miss_c%0d", i), ctl, 7'b1111001);
      tick;
    end
    MissM = 1'b0; RefillDone = 1'b1;
    #1;
    chk("miss_refill", ctl, 7'b1111001);
    tick;
    RefillDone = 1'b0; MissM = 1'b1;
    #1;
    chk("resume", ctl, 7'b1111001);
    tick;
    MissM = 1'b0;
    #1;
    chk("after_resume", ctl, 7'b0000000);
    chk("no_err_64", MemErr, 0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    chk("dut4_err_cleared", MemErr4, 0);
    MissM = 1'b1;
    #1;
    chk("to_detect", ctl4, 7'b1111001);
    tick;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("to_miss%0d_noerr", i), MemErr4, 0);
      tick;
    end
    chk("to_err_set", MemErr4, 1);
    chk("to_still_stall", ctl4, 7'b1111001);
    tick;
    chk("to_err_hold", MemErr4, 1);
    MissM = 1'b0; RefillDone = 1'b1;
    tick;
    RefillDone = 1'b0;
    #1;
    chk("to_resume", ctl4, 7'b1111001);
    tick;
    chk("to_run", ctl4, 7'b0000000);
    chk("to_err_sticky", MemErr4, 1);
    chk("to_dut64_noerr", MemErr, 0);
    MissM = 1'b1;
    tick;
    tick;
    chk("mid_miss_stall", ctl, 7'b1111001);
    rst = 1'b1;
    #1;
    chk("mid_miss_rst_ctl", ctl, 7'b0000111);
    tick;
    rst = 1'b0; MissM = 1'b0;
    #1;
    chk("post_rst_ctl", ctl, 7'b0000000);
    chk("post_rst_err", MemErr4, 0);
    RefillDone = 1'b1;
    #1;
    chk("refill_in_run", ctl, 7'b0000000);
    tick;
    RefillDone = 1'b0;
    #1;
    chk("refill_ignored", ctl, 7'b0000000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
